digit_serial_comparator: RTL and testbench

Parametrised, multi-cycle magnitude comparator that compares two WIDTH-bit operands most-significant digit first, DIGIT bits per clock, with a start/busy/done handshake. It is the next generation of our 8-bit cascaded less/equal comparator. It adds generic width, selectable signed/unsigned compare and optional early termination on the first differing digit. It also holds registered one-hot result flags. It sits beside the datapath as a shared compare resource that is time-multiplexed between requesters.

---
 rtl/digit_serial_comparator_if.sv | 26 ++
 rtl/digit_serial_comparator.sv | 119 +++++++++++
 tb/tb_digit_serial_comparator.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/digit_serial_comparator_if.sv
// Start/busy/done handshake bundle for the digit-serial comparator.
interface digit_serial_comparator_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             A_less_B;
    logic             A_equal_B;
    logic             A_great_B;

    modport master (
        output start, signed_mode, A, B,
        input  busy, done,
        input  A_less_B, A_equal_B, A_great_B
    );

    modport slave (
        input  start, signed_mode, A, B,
        output busy, done,
        output A_less_B, A_equal_B, A_great_B
    );
endinterface

// File: rtl/digit_serial_comparator.sv
// Multi-cycle MSD-first magnitude comparator, DIGIT bits per clock,
// with signed/unsigned mode and optional early exit on first difference.
module digit_serial_comparator #(
    parameter int WIDTH      = 16,
    parameter int DIGIT      = 4,
    parameter bit EARLY_EXIT = 1'b1
) (
    input logic                      clk,
    input logic                      rst_n,
    digit_serial_comparator_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [CW-1:0]    cnt;
    logic             decided;
    logic             dec_less;
    logic             done_q;
    logic             less_q;
    logic             equal_q;
    logic             great_q;

    logic [DIGIT-1:0] da;
    logic [DIGIT-1:0] db;
    logic             differ;
    logic             last;
    logic             capture;
    logic             finish;
    logic             res_less;
    logic             res_great;

    assign da     = sa[WIDTH-1 -: DIGIT];
    assign db     = sb[WIDTH-1 -: DIGIT];
    assign differ = (da != db);
    assign last   = (cnt == CW'(N - 1));

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        finish     = 1'b0;
        res_less   = 1'b0;
        res_great  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    capture    = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                finish = last || (EARLY_EXIT && differ);
                // A sticky decision outranks whatever later digits say
                if (decided) begin
                    res_less  = dec_less;
                    res_great = !dec_less;
                end else if (differ) begin
                    res_less  = (da < db);
                    res_great = (da > db);
                end
                if (finish) begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sa       <= '0;
            sb       <= '0;
            cnt      <= '0;
            decided  <= 1'b0;
            dec_less <= 1'b0;
            done_q   <= 1'b0;
            less_q   <= 1'b0;
            equal_q  <= 1'b0;
            great_q  <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= finish;
            if (capture) begin
                // Flipping the sign bit maps two's complement to offset binary
                sa       <= {bus.A[WIDTH-1] ^ bus.signed_mode,
                             bus.A[WIDTH-2:0]};
                sb       <= {bus.B[WIDTH-1] ^ bus.signed_mode,
                             bus.B[WIDTH-2:0]};
                cnt      <= '0;
                decided  <= 1'b0;
                dec_less <= 1'b0;
            end else if (state == RUN) begin
                sa  <= sa << DIGIT;
                sb  <= sb << DIGIT;
                cnt <= cnt + CW'(1);
                if (differ && !decided) begin
                    decided  <= 1'b1;
                    dec_less <= (da < db);
                end
            end
            if (finish) begin
                less_q  <= res_less;
                equal_q <= !res_less && !res_great;
                great_q <= res_great;
            end
        end
    end

    assign bus.busy      = (state == RUN);
    assign bus.done      = done_q;
    assign bus.A_less_B  = less_q;
    assign bus.A_equal_B = equal_q;
    assign bus.A_great_B = great_q;
endmodule

// File: tb/tb_digit_serial_comparator.sv
// Directed and randomized checks of digit_serial_comparator against
// an arithmetic reference model, over several WIDTH/DIGIT/EARLY_EXIT sets.
module tb_digit_serial_comparator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errs = 0;
    int   checks = 0;
    bit   sweep_go = 1'b0;
    bit   sweep_fin [6];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    digit_serial_comparator_if #(.WIDTH(16)) m_if ();
    digit_serial_comparator_if #(.WIDTH(16)) z_if ();

    digit_serial_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(1'b1)) m_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m_if)
    );

    digit_serial_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(1'b0)) z_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (z_if)
    );

    function automatic logic [2:0] flags(input bit sel);
        if (sel) return {z_if.A_less_B, z_if.A_equal_B, z_if.A_great_B};
        return {m_if.A_less_B, m_if.A_equal_B, m_if.A_great_B};
    endfunction

    task automatic launch(input bit sel, input logic [15:0] a,
                          input logic [15:0] b, input bit sm);
        @(negedge clk);
        if (sel) begin
            z_if.start = 1'b1; z_if.A = a; z_if.B = b; z_if.signed_mode = sm;
        end else begin
            m_if.start = 1'b1; m_if.A = a; m_if.B = b; m_if.signed_mode = sm;
        end
        @(posedge clk);
        #1;
        m_if.start = 1'b0;
        z_if.start = 1'b0;
    endtask

    task automatic wait_done(input bit sel, output int lat, output int bc);
        lat = 0;
        bc  = 0;
        if (sel ? z_if.busy : m_if.busy) bc++;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            lat++;
            if (sel ? z_if.done : m_if.done) break;
            if (sel ? z_if.busy : m_if.busy) bc++;
        end
        check("busy_in_done", sel ? z_if.busy : m_if.busy, 0);
    endtask

    task automatic dir(input string tag, input bit sel, input logic [15:0] a,
                       input logic [15:0] b, input bit sm,
                       input int exp_lat, input logic [2:0] exp_fl);
        int lat;
        int bc;
        launch(sel, a, b, sm);
        wait_done(sel, lat, bc);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_busy"}, bc, exp_lat);
        check({tag, "_flags"}, flags(sel), exp_fl);
    endtask

    for (genvar gi = 0; gi < 6; gi++) begin : g
        localparam int W = (gi == 0 || gi == 3) ? 8 :
                           (gi == 1 || gi == 4) ? 16 : 32;
        localparam int D = (gi == 0 || gi == 4) ? 1 :
                           (gi == 1 || gi == 5) ? 2 : 8;
        localparam bit E = (gi % 2 == 0);
        localparam int N = W / D;

        digit_serial_comparator_if #(.WIDTH(W)) s_if ();

        digit_serial_comparator #(.WIDTH(W), .DIGIT(D), .EARLY_EXIT(E)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (s_if)
        );

        initial begin
            logic [31:0] a;
            logic [31:0] b;
            logic [31:0] x;
            logic [31:0] mask;
            logic [2:0]  efl;
            bit          sm;
            int          kind;
            int          lat;
            int          exp_lat;
            int          p;
            longint      va;
            longint      vb;
            s_if.start = 1'b0;
            s_if.signed_mode = 1'b0;
            s_if.A = '0;
            s_if.B = '0;
            sweep_fin[gi] = 1'b0;
            mask = 32'hFFFF_FFFF >> (32 - W);
            wait (sweep_go);
            for (int t = 0; t < 40; t++) begin
                a = $urandom & mask;
                kind = $urandom_range(0, 3);
                if (kind == 0) b = a;
                else if (kind == 1) b = a ^ (32'd1 << $urandom_range(0, W - 1));
                else b = $urandom & mask;
                sm = 1'($urandom_range(0, 1));
                va = longint'(a);
                vb = longint'(b);
                if (sm && a[W-1]) va = va - (64'sd1 <<< W);
                if (sm && b[W-1]) vb = vb - (64'sd1 <<< W);
                efl = (va < vb) ? 3'b100 : (va == vb) ? 3'b010 : 3'b001;
                x = a ^ b;
                if (x == 0 || !E) begin
                    exp_lat = N;
                end else begin
                    p = 0;
                    for (int j = 0; j < W; j++) if (x[j]) p = j;
                    exp_lat = (W - 1 - p) / D + 1;
                end
                @(negedge clk);
                s_if.start = 1'b1;
                s_if.A = a[W-1:0];
                s_if.B = b[W-1:0];
                s_if.signed_mode = sm;
                @(posedge clk);
                #1;
                s_if.start = 1'b0;
                check("sw_busy", s_if.busy, 1);
                lat = 0;
                for (int c = 0; c < 40; c++) begin
                    @(posedge clk);
                    #1;
                    lat++;
                    if (s_if.done) break;
                end
                check("sw_lat", lat, exp_lat);
                check("sw_flags", {s_if.A_less_B, s_if.A_equal_B,
                                   s_if.A_great_B}, efl);
                check("sw_onehot", $countones({s_if.A_less_B, s_if.A_equal_B,
                                               s_if.A_great_B}), 1);
            end
            sweep_fin[gi] = 1'b1;
        end
    end

    initial begin
        int lat;
        int bc;
        int nd;
        int nfin;
        m_if.start = 1'b0; m_if.signed_mode = 1'b0; m_if.A = '0; m_if.B = '0;
        z_if.start = 1'b0; z_if.signed_mode = 1'b0; z_if.A = '0; z_if.B = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", m_if.busy, 0);
        check("rst_done", m_if.done, 0);
        check("rst_flags", flags(0), 3'b000);
        check("rst_flags_z", flags(1), 3'b000);
        @(negedge clk);
        rst_n = 1'b1;

        dir("lsd_less", 0, 16'h1234, 16'h1235, 0, 4, 3'b100);
        dir("msb_uns", 0, 16'h8000, 16'h7FFF, 0, 1, 3'b001);
        dir("msb_sgn", 0, 16'h8000, 16'h7FFF, 1, 1, 3'b100);
        dir("eq_ee1", 0, 16'hABCD, 16'hABCD, 0, 4, 3'b010);
        dir("eq_ee0", 1, 16'hABCD, 16'hABCD, 1, 4, 3'b010);
        dir("sticky", 1, 16'h9000, 16'h1000, 0, 4, 3'b001);
        dir("sgn_neg", 1, 16'hFFFF, 16'h0001, 1, 4, 3'b100);

        // Start pulsed mid-run must be dropped
        launch(0, 16'h1234, 16'h1235, 0);
        @(posedge clk);
        @(negedge clk);
        m_if.start = 1'b1; m_if.A = 16'hFFFF; m_if.B = 16'h0000;
        m_if.signed_mode = 1'b0;
        @(posedge clk);
        #1;
        m_if.start = 1'b0;
        lat = 2;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            lat++;
            if (m_if.done) break;
        end
        check("ign_lat", lat, 4);
        check("ign_flags", flags(0), 3'b100);
        nd = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (m_if.done) nd++;
        end
        check("ign_nodone", nd, 0);

        dir("b2b_first", 0, 16'h00F0, 16'h00E0, 0, 3, 3'b001);
        dir("b2b_second", 0, 16'h0001, 16'h0002, 0, 4, 3'b100);

        // Asynchronous reset in the middle of a compare
        launch(0, 16'h1234, 16'h1235, 0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", m_if.busy, 0);
        check("arst_done", m_if.done, 0);
        check("arst_flags", flags(0), 3'b000);
        check("arst_flags_z", flags(1), 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (m_if.done || m_if.busy) nd++;
        end
        check("arst_quiet", nd, 0);
        dir("post_rst", 0, 16'h8000, 16'h7FFF, 1, 1, 3'b100);
        launch(1, 16'h0F00, 16'h0E00, 0);
        wait_done(1, lat, bc);
        check("post_rst_z_lat", lat, 4);
        check("post_rst_z_flags", flags(1), 3'b001);

        sweep_go = 1'b1;
        nfin = 0;
        for (int c = 0; c < 20000; c++) begin
            @(posedge clk);
            nfin = 0;
            for (int i = 0; i < 6; i++) if (sweep_fin[i]) nfin++;
            if (nfin == 6) break;
        end
        check("sweep_complete", nfin, 6);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
